// File: rtl/isi_channel_fir_pkg.sv
// Shared constants and helpers for the isi_channel_fir PAM-4 channel model.
// Optional noise source is enabled with the ISI_CHANNEL_NOISE_EN macro.
package isi_channel_pkg;

  localparam logic signed [7:0] PAM4_NEG3 = -8'sd48;
  localparam logic signed [7:0] PAM4_NEG1 = -8'sd16;
  localparam logic signed [7:0] PAM4_POS1 = 8'sd16;
  localparam logic signed [7:0] PAM4_POS3 = 8'sd48;

  // Galois form of x^16+x^14+x^13+x^11+1, right-shifting.
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic int acc_width(input int sig_w, input int coef_w, input int taps);
    return sig_w + coef_w + $clog2(taps);
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] val,
                                                  input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 32'sd1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (val > max_v) begin
      saturate = max_v;
    end else if (val < min_v) begin
      saturate = min_v;
    end else begin
      saturate = val;
    end
  endfunction

endpackage

// File: rtl/isi_channel_fir_if.sv
// Sample-stream handshake bundle for isi_channel_fir (input and output sides).
interface isi_channel_fir_if #(
  parameter int SIGNAL_RESOLUTION = 8
) ();
  logic signed [SIGNAL_RESOLUTION-1:0] signal_in;
  logic                                signal_in_valid;
  logic                                signal_in_ready;
  logic signed [SIGNAL_RESOLUTION-1:0] signal_out;
  logic                                signal_out_valid;
  logic                                signal_out_ready;

  modport master (
    output signal_in, signal_in_valid, signal_out_ready,
    input  signal_in_ready, signal_out, signal_out_valid
  );

  modport slave (
    input  signal_in, signal_in_valid, signal_out_ready,
    output signal_in_ready, signal_out, signal_out_valid
  );
endinterface

// File: rtl/isi_noise_lfsr.sv
// 16-bit Galois LFSR noise source; compiled only when ISI_CHANNEL_NOISE_EN is defined.
`ifdef ISI_CHANNEL_NOISE_EN
module isi_noise_lfsr
  import isi_channel_pkg::*;
#(
  parameter int NOISE_BITS = 3
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         step,
  output logic signed [NOISE_BITS-1:0] noise
);
  logic [15:0] state_r;

  assign noise = $signed(state_r[NOISE_BITS-1:0]);

  // LFSR state: seeded on reset, advances once per accepted sample.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= LFSR_SEED;
    end else if (step) begin
      state_r <= {1'b0, state_r[15:1]} ^ (state_r[0] ? LFSR_POLY : 16'h0000);
    end else begin
      state_r <= state_r;
    end
  end
endmodule
`endif

// File: rtl/isi_channel_fir.sv
// PAM-4 ISI channel: two-stage FIR over a runtime pulse response with saturation.
// Define ISI_CHANNEL_NOISE_EN to add LFSR noise before saturation.
module isi_channel_fir
  import isi_channel_pkg::*;
#(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int TAP_COUNT         = 4,
  parameter int COEF_WIDTH        = 8,
  parameter int COEF_FRAC         = 6,
  parameter int NOISE_BITS        = 3
) (
  input  logic                          clk,
  input  logic                          rstn,
  isi_channel_fir_if.slave              stream,
  input  logic                          coef_wr_en,
  input  logic [$clog2(TAP_COUNT)-1:0]  coef_wr_addr,
  input  logic signed [COEF_WIDTH-1:0]  coef_wr_data,
  input  logic                          coef_commit,
  output logic [15:0]                   sat_cnt
);
  localparam int AW    = $clog2(TAP_COUNT);
  localparam int PW    = SIGNAL_RESOLUTION + COEF_WIDTH;
  localparam int ACC_W = acc_width(SIGNAL_RESOLUTION, COEF_WIDTH, TAP_COUNT);
  localparam int SW    = ACC_W + 1;
  localparam logic signed [COEF_WIDTH-1:0] COEF_ONE = COEF_WIDTH'(32'sd1 <<< COEF_FRAC);

  logic                                advance_s;
  logic                                accept_s;
  logic signed [SIGNAL_RESOLUTION-1:0] hist_r     [TAP_COUNT-1];
  logic signed [SIGNAL_RESOLUTION-1:0] tap_s      [TAP_COUNT];
  logic signed [COEF_WIDTH-1:0]        coef_act_r [TAP_COUNT];
  logic signed [COEF_WIDTH-1:0]        coef_shd_r [TAP_COUNT];
  logic signed [PW-1:0]                prod_r     [TAP_COUNT];
  logic                                s1_valid_r;
  logic signed [NOISE_BITS-1:0]        noise_s;
  logic signed [NOISE_BITS-1:0]        s1_noise_r;
  logic signed [ACC_W-1:0]             sum_s;
  logic signed [ACC_W-1:0]             shifted_s;
  logic signed [SW-1:0]                pre_sat_s;
  logic signed [63:0]                  wide_s;
  logic signed [63:0]                  sat_s;
  logic                                clip_s;
  logic signed [SIGNAL_RESOLUTION-1:0] out_r;
  logic                                out_valid_r;
  logic [15:0]                         sat_cnt_r;

  // Both stages move together; the input side only sees downstream state.
  assign advance_s              = !out_valid_r || stream.signal_out_ready;
  assign accept_s               = stream.signal_in_valid && advance_s;
  assign stream.signal_in_ready = advance_s;
  assign stream.signal_out      = out_r;
  assign stream.signal_out_valid = out_valid_r;
  assign sat_cnt                = sat_cnt_r;

`ifdef ISI_CHANNEL_NOISE_EN
  isi_noise_lfsr #(.NOISE_BITS(NOISE_BITS)) u_noise (
    .clk   (clk),
    .rstn  (rstn),
    .step  (accept_s),
    .noise (noise_s)
  );
`else
  assign noise_s = '0;
`endif

  // Tap vector: current sample at the cursor, then the delay line.
  always_comb begin
    tap_s[0] = stream.signal_in;
    for (int k = 1; k < TAP_COUNT; k++) begin
      tap_s[k] = hist_r[k-1];
    end
  end

  // Delay line shifts only on accepted samples.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < TAP_COUNT - 1; k++) hist_r[k] <= '0;
    end else if (accept_s) begin
      hist_r[0] <= stream.signal_in;
      for (int k = 1; k < TAP_COUNT - 1; k++) hist_r[k] <= hist_r[k-1];
    end else begin
      for (int k = 0; k < TAP_COUNT - 1; k++) hist_r[k] <= hist_r[k];
    end
  end

  // Coefficient banks; commit copies the pre-write shadow thanks to NBA ordering.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < TAP_COUNT; k++) begin
        coef_act_r[k] <= (k == 0) ? COEF_ONE : '0;
        coef_shd_r[k] <= (k == 0) ? COEF_ONE : '0;
      end
    end else begin
      for (int k = 0; k < TAP_COUNT; k++) begin
        if (coef_wr_en && (coef_wr_addr == AW'(k))) begin
          coef_shd_r[k] <= coef_wr_data;
        end else begin
          coef_shd_r[k] <= coef_shd_r[k];
        end
        if (coef_commit) begin
          coef_act_r[k] <= coef_shd_r[k];
        end else begin
          coef_act_r[k] <= coef_act_r[k];
        end
      end
    end
  end

  // Stage 1: tap products against the active bank.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_r <= 1'b0;
      s1_noise_r <= '0;
      for (int k = 0; k < TAP_COUNT; k++) prod_r[k] <= '0;
    end else if (advance_s) begin
      s1_valid_r <= accept_s;
      s1_noise_r <= noise_s;
      for (int k = 0; k < TAP_COUNT; k++) begin
        prod_r[k] <= PW'(tap_s[k]) * PW'(coef_act_r[k]);
      end
    end else begin
      s1_valid_r <= s1_valid_r;
      s1_noise_r <= s1_noise_r;
      for (int k = 0; k < TAP_COUNT; k++) prod_r[k] <= prod_r[k];
    end
  end

  // Sum, floor-shift out the fraction, add noise and clamp.
  always_comb begin
    sum_s = '0;
    for (int k = 0; k < TAP_COUNT; k++) begin
      sum_s = sum_s + ACC_W'(prod_r[k]);
    end
    shifted_s = sum_s >>> COEF_FRAC;
    pre_sat_s = SW'(shifted_s) + SW'(s1_noise_r);
    wide_s    = 64'(pre_sat_s);
    sat_s     = saturate(wide_s, SIGNAL_RESOLUTION);
    clip_s    = (sat_s != wide_s);
  end

  // Stage 2: output register and sticky saturation counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_r       <= '0;
      out_valid_r <= 1'b0;
      sat_cnt_r   <= 16'h0000;
    end else if (advance_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_r <= sat_s[SIGNAL_RESOLUTION-1:0];
      end else begin
        out_r <= out_r;
      end
      if (s1_valid_r && clip_s && (sat_cnt_r != 16'hFFFF)) begin
        sat_cnt_r <= sat_cnt_r + 16'h0001;
      end else begin
        sat_cnt_r <= sat_cnt_r;
      end
    end else begin
      out_r       <= out_r;
      out_valid_r <= out_valid_r;
      sat_cnt_r   <= sat_cnt_r;
    end
  end
endmodule

// File: tb/tb_isi_channel_fir.sv
// Scoreboard bench for isi_channel_fir (default parameters, noise disabled).
module tb_isi_channel_fir;
  import isi_channel_pkg::*;

  localparam int SR = 8;
  localparam int TC = 4;
  localparam int CW = 8;
  localparam int CF = 6;

  logic              clk = 1'b0;
  logic              rstn;
  logic              coef_wr_en;
  logic [1:0]        coef_wr_addr;
  logic signed [7:0] coef_wr_data;
  logic              coef_commit;
  logic [15:0]       sat_cnt;

  always #5 clk = ~clk;

  isi_channel_fir_if #(.SIGNAL_RESOLUTION(SR)) bus ();

  isi_channel_fir #(
    .SIGNAL_RESOLUTION(SR), .TAP_COUNT(TC), .COEF_WIDTH(CW), .COEF_FRAC(CF), .NOISE_BITS(3)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .stream       (bus),
    .coef_wr_en   (coef_wr_en),
    .coef_wr_addr (coef_wr_addr),
    .coef_wr_data (coef_wr_data),
    .coef_commit  (coef_commit),
    .sat_cnt      (sat_cnt)
  );

  typedef struct {
    int val;
    int cyc_in;
    bit chk_lat;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   lat_mode = 1'b0;

  // Reference model state: plain convolution over a sample history.
  int m_act[TC];
  int m_shd[TC];
  int m_xs[$];
  int m_sat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < TC; k++) begin
      m_act[k] = (k == 0) ? 64 : 0;
      m_shd[k] = (k == 0) ? 64 : 0;
    end
    m_xs.delete();
    m_sat = 0;
  endfunction

  // y[n] = floor(sum h[k]*x[n-k] / 2^CF), clamped to the signed output range.
  function automatic int model_out(input int x);
    int sum;
    int y;
    m_xs.push_front(x);
    sum = 0;
    for (int k = 0; k < TC; k++) begin
      if (k < m_xs.size()) sum += m_act[k] * m_xs[k];
    end
    y = int'($floor(real'(sum) / real'(1 << CF)));
    if (y > 127) begin
      y = 127;
      m_sat++;
    end else if (y < -128) begin
      y = -128;
      m_sat++;
    end
    return y;
  endfunction

  // Monitor: pops the scoreboard on every output transfer.
  always @(negedge clk) begin
    if (rstn === 1'b1 && bus.signal_out_valid && bus.signal_out_ready) begin
      if (sbq.size() == 0) begin
        check("unexpected_output", int'(bus.signal_out), 9999);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("out_value", int'(bus.signal_out), e.val);
        if (e.chk_lat) check("latency", cyc - e.cyc_in, 2);
      end
    end
    if (rstn === 1'b1 && bus.signal_out_valid && !bus.signal_out_ready) begin
      check("in_ready_stall", int'(bus.signal_in_ready), 0);
    end
  end

  task automatic drive(input bit v, input int d, input bit ordy,
                       input bit we, input int wa, input int wd, input bit cm);
    @(posedge clk);
    #1;
    bus.signal_in        = 8'(d);
    bus.signal_in_valid  = v;
    bus.signal_out_ready = ordy;
    coef_wr_en           = we;
    coef_wr_addr         = 2'(wa);
    coef_wr_data         = 8'(wd);
    coef_commit          = cm;
    @(negedge clk);
    if (v && bus.signal_in_ready) begin
      exp_t e;
      e.val     = model_out(d);
      e.cyc_in  = cyc;
      e.chk_lat = lat_mode;
      sbq.push_back(e);
    end
    if (cm) m_act = m_shd;
    if (we) m_shd[wa] = wd;
  endtask

  task automatic load_coefs(input int c0, input int c1, input int c2, input int c3);
    drive(1'b0, 0, 1'b1, 1'b1, 0, c0, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b1, 1, c1, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b1, 2, c2, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b1, 3, c3, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b0, 0, 0, 1'b1);
  endtask

  task automatic send4(input int a, input int b, input int c, input int d);
    drive(1'b1, a, 1'b1, 1'b0, 0, 0, 1'b0);
    drive(1'b1, b, 1'b1, 1'b0, 0, 0, 1'b0);
    drive(1'b1, c, 1'b1, 1'b0, 0, 0, 1'b0);
    drive(1'b1, d, 1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sbq.size() != 0; i++) begin
      drive(1'b0, 0, 1'b1, 1'b0, 0, 0, 1'b0);
    end
    drive(1'b0, 0, 1'b1, 1'b0, 0, 0, 1'b0);
    check("drain_pending", sbq.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn                 = 1'b0;
    bus.signal_in_valid  = 1'b0;
    bus.signal_out_ready = 1'b1;
    coef_wr_en           = 1'b0;
    coef_commit          = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out_valid", int'(bus.signal_out_valid), 0);
    check("rst_out", int'(bus.signal_out), 0);
    check("rst_sat_cnt", int'(sat_cnt), 0);
    check("rst_in_ready", int'(bus.signal_in_ready), 1);
    sbq.delete();
    model_reset();
    rstn = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn                 = 1'b0;
    bus.signal_in        = '0;
    bus.signal_in_valid  = 1'b0;
    bus.signal_out_ready = 1'b1;
    coef_wr_en           = 1'b0;
    coef_wr_addr         = 2'd0;
    coef_wr_data         = 8'sd0;
    coef_commit          = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Identity channel: PAM-4 levels pass straight through with latency 2.
    lat_mode = 1'b1;
    send4(int'(PAM4_NEG3), int'(PAM4_NEG1), int'(PAM4_POS1), int'(PAM4_POS3));
    drain();
    lat_mode = 1'b0;
    check("sat_cnt_identity", int'(sat_cnt), 0);

    // One post-cursor of half weight.
    load_coefs(64, 32, 0, 0);
    send4(48, 0, 0, 0);
    send4(-48, 0, 0, 0);
    drain();

    // Saturation on the accumulated sum.
    load_coefs(64, 64, 64, 64);
    send4(48, 48, 48, 48);
    drain();
    check("sat_cnt_clip", int'(sat_cnt), 2);

    // Commit in the same cycle as an accepted sample: that sample uses the old bank.
    do_reset();
    drive(1'b0, 0, 1'b1, 1'b1, 1, 32, 1'b0);
    drive(1'b1, 48, 1'b1, 1'b0, 0, 0, 1'b1);
    drive(1'b1, 0, 1'b1, 1'b0, 0, 0, 1'b0);
    drive(1'b1, 0, 1'b1, 1'b0, 0, 0, 1'b0);
    drain();

    // Random stream with random coefficient traffic and a 5-cycle stall.
    load_coefs($urandom_range(0, 127) - 64, $urandom_range(0, 127) - 64,
               $urandom_range(0, 127) - 64, $urandom_range(0, 127) - 64);
    for (int i = 0; i < 60; i++) begin
      bit v;
      bit we;
      bit cm;
      v  = ($urandom_range(0, 9) < 8);
      we = ($urandom_range(0, 9) < 2);
      cm = ($urandom_range(0, 9) < 1);
      drive(v, $urandom_range(0, 255) - 128, !(i >= 20 && i < 25),
            we, $urandom_range(0, 3), $urandom_range(0, 255) - 128, cm);
    end
    drain();
    check("sat_cnt_random", int'(sat_cnt), m_sat);

    // Reset mid-stream clears history and loaded coefficients.
    load_coefs(64, 32, 16, 8);
    drive(1'b1, 48, 1'b1, 1'b0, 0, 0, 1'b0);
    drive(1'b1, -16, 1'b1, 1'b0, 0, 0, 1'b0);
    do_reset();
    send4(48, 0, 0, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
